muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Produces the ALU_stall input of the hazard detection unit.
- That stall holds PC and IF/ID, and freezes EX, while a dependent HI/LO instruction waits for an in-flight operation.

Parameters:
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- valid_i  in  1  a mul/div-class instruction is in EX this cycle.
- op_i  in  3  operation, encoded as in the package: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
- src_a_i  in  WIDTH  rs value after forwarding.
- src_b_i  in  WIDTH  rt value after forwarding.
- abort_i  in  1  PCSrc-qualified EX flush; kills the instruction in EX only.
- result_o  out  WIDTH  MFHI/MFLO read data, or 0.
- busy_o  out  1  an operation is in flight.
- alu_stall_o  out  1  goes to ALU_stall of the hazard unit.

Behaviour:
- Reset (rst_i=0 at an edge):
  - State is IDLE.
  - HI=0, LO=0, counter=0.
  - busy_o=0, alu_stall_o=0, result_o=0.
  - Any in-flight operation is discarded.
- State machine has three states: IDLE, CALC, FIX.
- IDLE, accepting an operation:
  - MULT/MULTU/DIV/DIVU are accepted when valid_i=1, abort_i=0 and busy_o=0.
  - On acceptance: latch the magnitudes of both operands (signed ops only), the result sign and the op; set counter=WIDTH; go to CALC.
- CALC:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring shift-subtract step per cycle.
  - counter decrements each cycle; at counter==1, go to FIX.
- FIX (1 cycle):
  - Apply sign correction, write HI/LO, return to IDLE.
  - Multiply: HI:LO is the 2*WIDTH-bit product.
  - Divide: LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
- Latency: busy_o=1 for exactly WIDTH+1 cycles after the accept edge (33 for the default). New HI/LO values are visible on the cycle after busy_o falls.
- Divide boundary cases:
  - Divide by zero: LO=all ones, HI=src_a; no exception.
  - Signed DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: write src_a_i into HI/LO at the edge when valid_i=1, abort_i=0 and busy_o=0.
- MFHI/MFLO: result_o = HI or LO combinationally when valid_i=1 and busy_o=0; otherwise result_o=0.
- Stall rule: alu_stall_o = busy_o & valid_i & ~abort_i, for any op_i. Non-mul/div instructions never stall.
- Simultaneous events:
  - abort_i together with a start: the start is ignored.
  - abort_i while in CALC: the in-flight operation continues; it belongs to an older, committed instruction.
- While alu_stall_o=1, the requesting instruction stays in EX. It is re-evaluated every cycle and proceeds on the first cycle that busy_o=0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply loads counter with the bit length of |src_b| (minimum 1) instead of WIDTH.
  - Latency becomes len+1 cycles, e.g. 7*5 gives 3 CALC cycles + FIX = 4 cycles busy.
  - Divide is unchanged.
- Undefined: fixed WIDTH+1 latency for all operations.

Decomposition:
- Package mips_muldiv_pkg holds:
  - op encodings;
  - state enum {IDLE, CALC, FIX};
  - DIV0_QUOT constant (all ones).
- One natural sub-module, muldiv_step: the combinational one-iteration datapath (add/sub and shift) for multiply and divide. The FSM, counter and HI/LO stay in muldiv_unit.

Test Plan:
- MULT, src_a=0xFFFFFFFD (-3), src_b=7, then MFLO issued next cycle:
  - alu_stall_o=1 for 33 cycles, then result_o=0xFFFFFFEB;
  - MFHI then gives 0xFFFFFFFF.
- DIVU 100/7, then MFHI, then MFLO → 2, then 14.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by zero with src_a=0x1234 → LO=0xFFFFFFFF, HI=0x1234.
- MULT with abort_i=1 on the start cycle → busy_o stays 0 and HI/LO are unchanged.
- rst_i=0 mid-CALC → next cycle busy_o=0, HI=LO=0.
- MTHI 0xA5A5A5A5 while busy → stalls until done, then HI=0xA5A5A5A5, overwriting the product's HI.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and the divide-by-zero quotient.
package mips_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add multiply or
// restoring shift-subtract divide (acc = remainder, mplier = quotient).
module muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   acc_n,
  output logic [2*WIDTH-1:0]   mcand_n,
  output logic [WIDTH-1:0]     mplier_n
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {acc[WIDTH-1:0], mplier[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand[WIDTH-1:0]};

  always_comb begin
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    if (is_div) begin
      acc_n    = {{WIDTH{1'b0}},
                  diff[WIDTH] ? shifted[WIDTH-1:0]
                              : diff[WIDTH-1:0]};
      mplier_n = {mplier[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      if (mplier[0])
        acc_n = acc + mcand;
      mcand_n  = mcand << 1;
      mplier_n = mplier >> 1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage iterative mul/div unit owning HI/LO; drives ALU_stall.
// Optional MULDIV_EARLY_OUT_EN: multiply iterates only over |src_b| bits.
module muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             alu_stall_o
);

  localparam int W2 = 2 * WIDTH;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  logic [W2-1:0]    acc_n;
  logic [W2-1:0]    mcand_n;
  logic [WIDTH-1:0] mplier_n;

  logic             is_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             go;
  logic             start;
  logic [CNT_W-1:0] cnt_init;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign busy_o      = (state != IDLE);
  assign alu_stall_o = busy_o & valid_i & ~abort_i;

  assign is_sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg  = is_sgn & src_a_i[WIDTH-1];
  assign b_neg  = is_sgn & src_b_i[WIDTH-1];
  assign abs_a  = a_neg ? -src_a_i : src_a_i;
  assign abs_b  = b_neg ? -src_b_i : src_b_i;
  assign go     = valid_i & ~abort_i & ~busy_o;
  assign start  = go & ~op_i[2];

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] len;

  always_comb begin
    len = CNT_W'(1);
    for (int i = 1; i < WIDTH; i++)
      if (abs_b[i])
        len = CNT_W'(i + 1);
  end

  assign cnt_init = op_i[1] ? CNT_W'(WIDTH) : len;
`else
  assign cnt_init = CNT_W'(WIDTH);
`endif

  assign prod  = neg_q ? -acc : acc;
  assign q_fix = neg_q ? -mplier : mplier;
  assign r_fix = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .mcand    (mcand),
    .mplier   (mplier),
    .acc_n    (acc_n),
    .mcand_n  (mcand_n),
    .mplier_n (mplier_n)
  );

  always_comb begin
    result_o = '0;
    if (valid_i && !busy_o) begin
      unique case (1'b1)
        (op_i == OP_MFHI): result_o = hi;
        (op_i == OP_MFLO): result_o = lo;
        default:           result_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // divide: mplier carries dividend in, quotient out
            is_div <= op_i[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (src_b_i == '0);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}},
                       op_i[1] ? abs_b : abs_a};
            mplier <= op_i[1] ? abs_a : abs_b;
            cnt    <= cnt_init;
            state  <= CALC;
          end else if (go && op_i == OP_MTHI) begin
            hi <= src_a_i;
          end else if (go && op_i == OP_MTLO) begin
            lo <= src_a_i;
          end
        end
        CALC: begin
          acc    <= acc_n;
          mcand  <= mcand_n;
          mplier <= mplier_n;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= div0 ? DIV0_QUOT[WIDTH-1:0] : q_fix;
            hi <= r_fix;
          end else begin
            hi <= prod[W2-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, corner
// sequences and random ops against an arithmetic reference model.
module tb_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         busy;
  logic         stall;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .op_i        (op),
    .src_a_i     (a),
    .src_b_i     (b),
    .abort_i     (abort),
    .result_o    (result),
    .busy_o      (busy),
    .alu_stall_o (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 1'b0;
    abort = 1'b0;
    op    = OP_MFHI;
  endtask

  function automatic void ref_op(input logic [2:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 output logic [W-1:0] h,
                                 output logic [W-1:0] l);
    int          sx;
    int          sy;
    longint      p;
    logic [63:0] u;
    sx = x;
    sy = y;
    h  = '0;
    l  = '0;
    case (o)
      OP_MULT: begin
        p = longint'(sx) * longint'(sy);
        {h, l} = p;
      end
      OP_MULTU: begin
        u = {32'd0, x} * {32'd0, y};
        {h, l} = u;
      end
      OP_DIV: begin
        if (y == 0) begin
          l = '1;
          h = x;
        end else if (x == 32'h8000_0000 && y == '1) begin
          l = x;
          h = '0;
        end else begin
          l = sx / sy;
          h = sx % sy;
        end
      end
      default: begin
        if (y == 0) begin
          l = '1;
          h = x;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o,
                                 input logic [W-1:0] y);
    int lat;
    lat = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [W-1:0] mag;
      mag = (o == OP_MULT && y[W-1]) ? -y : y;
      lat = 2;
      for (int i = 0; i < W; i++)
        if (mag[i])
          lat = i + 2;
    end
`else
    if (o[2])
      lat = 0;
`endif
    return lat;
  endfunction

  task automatic read_hl(output logic [W-1:0] h,
                         output logic [W-1:0] l);
    valid = 1'b1;
    abort = 1'b0;
    op    = OP_MFHI;
    #1 h  = result;
    op    = OP_MFLO;
    #1 l  = result;
    idle_in();
  endtask

  task automatic start_op(input logic [2:0] o,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y);
    valid = 1'b1;
    abort = 1'b0;
    op    = o;
    a     = x;
    b     = y;
    tick();
    idle_in();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_op(input string name,
                        input logic [2:0] o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic [W-1:0] eh,
                        input logic [W-1:0] el);
    int           n;
    logic [W-1:0] h;
    logic [W-1:0] l;
    start_op(o, x, y);
    wait_idle(n);
    check({name, " latency"}, 64'(n), 64'(exp_lat(o, y)));
    read_hl(h, l);
    check({name, " hi"}, 64'(h), 64'(eh));
    check({name, " lo"}, 64'(l), 64'(el));
  endtask

  initial begin
    int           n;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic [2:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    tbl[0] = '{"mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{"divu_100_7", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14};
    tbl[2] = '{"div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{"div_by0", OP_DIV, 32'h1234, 32'd0,
               32'h1234, 32'hFFFF_FFFF};
    tbl[4] = '{"div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000};
    tbl[5] = '{"multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001};
    tbl[6] = '{"divu_by0", OP_DIVU, 32'h8000_1234, 32'd0,
               32'h8000_1234, 32'hFFFF_FFFF};
    tbl[7] = '{"div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD};
    tbl[8] = '{"mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000};

    idle_in();
    rst = 1'b0;
    tick();
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset result idle", 64'(result), 64'd0);
    rst = 1'b1;
    tick();
    read_hl(h, l);
    check("reset hi", 64'(h), 64'd0);
    check("reset lo", 64'(l), 64'd0);

    // MULT then dependent MFLO held in EX
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    valid = 1'b0;
    #1 check("stall no valid", 64'(stall), 64'd0);
    valid = 1'b1;
    op    = OP_MFLO;
    #1 check("mflo while busy", 64'(result), 64'd0);
    n = 0;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    check("mflo stall cycles", 64'(n),
          64'(exp_lat(OP_MULT, 32'd7)));
    check("mflo after stall", 64'(result), 64'hFFFF_FFEB);
    op = OP_MFHI;
    #1 check("mfhi after stall", 64'(result), 64'hFFFF_FFFF);
    idle_in();
    tick();

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].hi, tbl[i].lo);

    // start killed by abort leaves HI/LO alone
    valid = 1'b1;
    op    = OP_MTHI;
    a     = 32'h1111_1111;
    tick();
    op    = OP_MTLO;
    a     = 32'h2222_2222;
    tick();
    op    = OP_MULT;
    a     = 32'd5;
    b     = 32'd6;
    abort = 1'b1;
    #1 check("abort start stall", 64'(stall), 64'd0);
    tick();
    check("abort start busy", 64'(busy), 64'd0);
    idle_in();
    read_hl(h, l);
    check("abort hi kept", 64'(h), 64'h1111_1111);
    check("abort lo kept", 64'(l), 64'h2222_2222);

    // abort during CALC flushes only the EX instruction
    start_op(OP_DIVU, 32'd100, 32'd7);
    valid = 1'b1;
    op    = OP_MFLO;
    abort = 1'b1;
    #1 check("abort calc stall", 64'(stall), 64'd0);
    abort = 1'b0;
    op    = 3'd0;
    #1 check("busy stall any op", 64'(stall), 64'd1);
    idle_in();
    wait_idle(n);
    check("abort calc latency", 64'(n),
          64'(exp_lat(OP_DIVU, 32'd7)));
    read_hl(h, l);
    check("abort calc hi", 64'(h), 64'd2);
    check("abort calc lo", 64'(l), 64'd14);

    // reset in the middle of CALC
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    tick();
    check("pre reset busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();
    check("mid reset busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();
    check("post reset busy", 64'(busy), 64'd0);
    read_hl(h, l);
    check("mid reset hi", 64'(h), 64'd0);
    check("mid reset lo", 64'(l), 64'd0);

    // MTHI waits out the multiply then overwrites HI
    start_op(OP_MULTU, 32'd3, 32'd5);
    valid = 1'b1;
    op    = OP_MTHI;
    a     = 32'hA5A5_A5A5;
    n     = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    check("mthi stall cycles", 64'(n),
          64'(exp_lat(OP_MULTU, 32'd5)));
    tick();
    idle_in();
    read_hl(h, l);
    check("mthi hi", 64'(h), 64'hA5A5_A5A5);
    check("mthi lo", 64'(l), 64'd15);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'h8000_0000;
        3: rb = '1;
        default: ;
      endcase
      ref_op(ro, ra, rb, eh, el);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, eh, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
